l2_instruction_responder: RTL and testbench

L2_INSTRUCTION_RESPONDER -- requirements
Module: l2_instruction_responder

---
 rtl/l2_ins_pkg.sv | 19 +
 rtl/l2_ins_request_fifo.sv | 66 ++++++
 rtl/l2_instruction_responder.sv | 127 ++++++++++++
 tb/tb_l2_instruction_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_ins_pkg.sv
// Shared constants and FSM encoding for the L2 instruction responder and its request queue.
// Default widths, the RISC-V NOP returned for out-of-range fetches, and the response FSM states.
package l2_ins_pkg;

  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_L2_BUS_WIDTH  = 32;
  localparam int DEF_QUEUE_DEPTH   = 4;
  localparam int DEF_MEMORY_DEPTH  = 1024;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/l2_ins_request_fifo.sv
// In-order request queue of word addresses; head visible combinationally, pop takes effect at the edge.
// Push ready is registered from the next occupancy, so it stays low on a full cycle even if a pop lands.
module l2_ins_request_fifo
  import l2_ins_pkg::*;
#(
  parameter int WIDTH = DEF_ADDRESS_WIDTH - 2,
  parameter int DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             push_rdy,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & rdy_q;
  assign do_pop   = pop & ~empty;
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign push_rdy = rdy_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Pointers are log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    rdy_d    = (count_d != (PW+1)'(DEPTH));
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b1;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/l2_instruction_responder.sv
// L2 instruction responder: queued L1 fetches, one outstanding memory read, response held until L1 ready (min 3 edges).
// Optional L2_INS_RANGE_CHECK_EN answers out-of-range fetches with a NOP and raises sticky RANGE_ERROR.
module l2_instruction_responder
  import l2_ins_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int L2_BUS_WIDTH  = DEF_L2_BUS_WIDTH,
  parameter int QUEUE_DEPTH   = DEF_QUEUE_DEPTH,
  parameter int MEMORY_DEPTH  = DEF_MEMORY_DEPTH
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            ADDRESS_TO_L2_VALID_INS,
  output logic                            ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0]        ADDRESS_TO_L2_INS,
  output logic                            DATA_FROM_L2_VALID_INS,
  input  logic                            DATA_FROM_L2_READY_INS,
  output logic [L2_BUS_WIDTH-1:0]         DATA_FROM_L2_INS,
  output logic                            MEM_READ_VALID,
  input  logic                            MEM_READ_READY,
  output logic [$clog2(MEMORY_DEPTH)-1:0] MEM_READ_ADDRESS,
  input  logic                            MEM_READ_DATA_VALID,
  input  logic [L2_BUS_WIDTH-1:0]         MEM_READ_DATA,
  output logic                            RANGE_ERROR
);

  localparam int WA = ADDRESS_WIDTH - 2;
  localparam int MA = $clog2(MEMORY_DEPTH);

  state_e                  state_q, state_d;
  logic [L2_BUS_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                    rsp_vld_q, rsp_vld_d;
  logic                    range_err_q, range_err_d;

  logic                    fifo_pop;
  logic                    fifo_empty;
  logic                    unused_fifo_full;
  logic [WA-1:0]           head_dat;
  logic                    head_oor;
  logic                    rsp_hs;
  logic                    launch;
  logic                    skip;

  l2_ins_request_fifo #(
    .WIDTH (WA),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (ADDRESS_TO_L2_VALID_INS),
    .push_dat (ADDRESS_TO_L2_INS),
    .pop      (fifo_pop),
    .push_rdy (ADDRESS_TO_L2_READY_INS),
    .full     (unused_fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat)
  );

`ifdef L2_INS_RANGE_CHECK_EN
  assign head_oor = (head_dat >= WA'(MEMORY_DEPTH));
`else
  // Upper address bits alias onto the memory; nothing is ever out of range.
  logic unused_head_hi;
  assign unused_head_hi = ^head_dat[WA-1:MA];
  assign head_oor       = 1'b0;
`endif

  assign rsp_hs = rsp_vld_q & DATA_FROM_L2_READY_INS;
  // A new head is started from IDLE, or straight out of RESP as the response is taken.
  assign launch = ~fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_hs));
  assign skip   = launch & head_oor;

  assign DATA_FROM_L2_VALID_INS = rsp_vld_q;
  assign DATA_FROM_L2_INS       = rsp_dat_q;
  assign RANGE_ERROR            = range_err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      rsp_dat_q   <= '0;
      rsp_vld_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_vld_q   <= rsp_vld_d;
      range_err_q <= range_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = skip ? ST_RESP : ST_REQ;
      ST_REQ:  if (MEM_READ_READY) state_d = ST_WAIT;
      ST_WAIT: if (MEM_READ_DATA_VALID) state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_hs) begin
          if (launch) state_d = skip ? ST_RESP : ST_REQ;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    MEM_READ_VALID   = (state_q == ST_REQ);
    MEM_READ_ADDRESS = (state_q == ST_REQ) ? head_dat[MA-1:0] : '0;
    fifo_pop         = ((state_q == ST_REQ) & MEM_READ_READY) | skip;
    rsp_vld_d        = rsp_vld_q;
    rsp_dat_d        = rsp_dat_q;
    range_err_d      = range_err_q | skip;
    if (rsp_hs) begin
      rsp_vld_d = 1'b0;
    end
    if ((state_q == ST_WAIT) & MEM_READ_DATA_VALID) begin
      rsp_vld_d = 1'b1;
      rsp_dat_d = MEM_READ_DATA;
    end
    if (skip) begin
      rsp_vld_d = 1'b1;
      rsp_dat_d = L2_BUS_WIDTH'(NOP_INS);
    end
  end

endmodule

// File: tb/tb_l2_instruction_responder.sv
// Directed bench for l2_instruction_responder: latency, queue full, in-order drain, L1 stall, reset, range check.
module tb_l2_instruction_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_vld;
  logic        addr_rdy;
  logic [29:0] addr;
  logic        dat_vld;
  logic        dat_rdy;
  logic [31:0] dat;
  logic        mem_vld;
  logic        mem_rdy;
  logic [9:0]  mem_addr;
  logic        mem_dv;
  logic [31:0] mem_dat;
  logic        range_err;

  logic        mem_auto;
  logic        acc;
  logic        rsp;
  logic        saw_mv;
  logic [9:0]  mv_addr;
  int          nacc;
  int          nresp;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  l2_instruction_responder dut (
    .CLK                     (clk),
    .RST                     (rst),
    .ADDRESS_TO_L2_VALID_INS (addr_vld),
    .ADDRESS_TO_L2_READY_INS (addr_rdy),
    .ADDRESS_TO_L2_INS       (addr),
    .DATA_FROM_L2_VALID_INS  (dat_vld),
    .DATA_FROM_L2_READY_INS  (dat_rdy),
    .DATA_FROM_L2_INS        (dat),
    .MEM_READ_VALID          (mem_vld),
    .MEM_READ_READY          (mem_rdy),
    .MEM_READ_ADDRESS        (mem_addr),
    .MEM_READ_DATA_VALID     (mem_dv),
    .MEM_READ_DATA           (mem_dat),
    .RANGE_ERROR             (range_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; when mem_auto is set, memory answers A000_0000|addr the cycle after each accept.
  task automatic tick;
    logic       hs;
    logic [9:0] a;
    hs = mem_vld & mem_rdy & mem_auto;
    a  = mem_addr;
    @(posedge clk);
    #1;
    mem_dv  = hs;
    mem_dat = hs ? (32'hA000_0000 | 32'(a)) : 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; addr_vld = 1'b0; addr = '0; dat_rdy = 1'b0;
    mem_rdy = 1'b0; mem_dv = 1'b0; mem_dat = '0; mem_auto = 1'b0;
    tick; tick;
    chk("rst_addr_rdy",  64'(addr_rdy),  64'd1);
    chk("rst_dat_vld",   64'(dat_vld),   64'd0);
    chk("rst_dat",       64'(dat),       64'd0);
    chk("rst_mem_vld",   64'(mem_vld),   64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_range_err", 64'(range_err), 64'd0);
    rst = 1'b0;
    tick;

    // Single request, zero-wait memory: data valid 3 edges after the address handshake.
    mem_rdy = 1'b1;
    addr_vld = 1'b1; addr = 30'h10;
    chk("single_addr_rdy", 64'(addr_rdy), 64'd1);
    tick;
    addr_vld = 1'b0;
    chk("single_e1_vld", 64'(dat_vld), 64'd0);
    tick;
    chk("single_req_vld",  64'(mem_vld),  64'd1);
    chk("single_req_addr", 64'(mem_addr), 64'h10);
    tick;
    chk("single_wait_mem_vld", 64'(mem_vld), 64'd0);
    chk("single_e2_vld",       64'(dat_vld), 64'd0);
    mem_dv = 1'b1; mem_dat = 32'hDEADBEEF;
    tick;
    chk("single_e3_vld", 64'(dat_vld), 64'd1);
    chk("single_e3_dat", 64'(dat),     64'hDEADBEEF);
    dat_rdy = 1'b1;
    tick;
    chk("single_taken", 64'(dat_vld), 64'd0);
    tick; tick; tick;
    chk("single_one_rsp", 64'({dat_vld, mem_vld}), 64'd0);

    // Back-to-back with memory stalled: ready drops after 4 accepts, then in-order drain.
    mem_auto = 1'b1; mem_rdy = 1'b0; dat_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_vld = 1'b1; addr = 30'(i);
      chk("b2b_rdy_before_full", 64'(addr_rdy), 64'd1);
      tick;
    end
    chk("b2b_full_rdy", 64'(addr_rdy), 64'd0);
    addr = 30'd4;
    tick;
    chk("b2b_full_rdy_held", 64'(addr_rdy), 64'd0);
    chk("b2b_head_req",      64'({mem_vld, mem_addr}), 64'({1'b1, 10'd0}));
    mem_rdy = 1'b1;
    nacc = 4; nresp = 0;
    for (int c = 0; c < 200 && nresp < 6; c++) begin
      acc = addr_vld & addr_rdy;
      rsp = dat_vld & dat_rdy;
      if (rsp) begin
        chk("b2b_order", 64'(dat), 64'(32'hA000_0000 | 32'(nresp)));
        nresp++;
      end
      tick;
      if (acc) begin
        nacc++;
        if (nacc < 6) addr = 30'(nacc);
        else addr_vld = 1'b0;
      end
    end
    chk("b2b_rsp_count", 64'(nresp), 64'd6);
    tick; tick; tick;
    chk("b2b_no_extra", 64'({dat_vld, mem_vld}), 64'd0);

    // L1 stall: response held, no new memory read until the handshake.
    dat_rdy = 1'b0;
    addr_vld = 1'b1; addr = 30'd7;
    tick;
    addr = 30'd8;
    tick;
    addr_vld = 1'b0;
    for (int c = 0; c < 20 && !dat_vld; c++) tick;
    chk("stall_first_vld", 64'(dat_vld), 64'd1);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("stall_hold", 64'({dat_vld, mem_vld, dat}), 64'({1'b1, 1'b0, 32'hA000_0007}));
    end
    dat_rdy = 1'b1;
    tick;
    chk("stall_release_vld", 64'(dat_vld), 64'd0);
    chk("stall_next_req",    64'({mem_vld, mem_addr}), 64'({1'b1, 10'd8}));
    for (int c = 0; c < 20 && !dat_vld; c++) tick;
    chk("stall_second_dat", 64'(dat), 64'hA000_0008);
    tick;
    chk("stall_second_taken", 64'(dat_vld), 64'd0);

    // Reset while a read is outstanding and another address is queued.
    mem_auto = 1'b0; mem_rdy = 1'b1; dat_rdy = 1'b0;
    addr_vld = 1'b1; addr = 30'd3;
    tick;
    addr = 30'd4;
    tick;
    addr_vld = 1'b0;
    chk("rstw_req", 64'(mem_vld), 64'd1);
    tick;
    chk("rstw_in_wait", 64'({mem_vld, dat_vld}), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_async_rdy", 64'(addr_rdy), 64'd1);
    tick;
    rst = 1'b0;
    mem_dv = 1'b1; mem_dat = 32'hDEADBEEF;
    tick;
    chk("rstw_late_data_vld", 64'(dat_vld), 64'd0);
    chk("rstw_late_data_dat", 64'(dat),     64'd0);
    tick; tick; tick;
    chk("rstw_queue_empty", 64'({mem_vld, dat_vld, addr_rdy}), 64'({1'b0, 1'b0, 1'b1}));

    // Address beyond the memory depth.
    mem_auto = 1'b1; mem_rdy = 1'b1; dat_rdy = 1'b0;
    addr_vld = 1'b1; addr = 30'd1024;
    tick;
    addr_vld = 1'b0;
    saw_mv = 1'b0; mv_addr = 10'h3FF;
    for (int c = 0; c < 20 && !dat_vld; c++) begin
      if (mem_vld) begin
        saw_mv = 1'b1; mv_addr = mem_addr;
      end
      tick;
    end
    chk("range_rsp_vld", 64'(dat_vld), 64'd1);
`ifdef L2_INS_RANGE_CHECK_EN
    chk("range_no_mem_read", 64'(saw_mv),    64'd0);
    chk("range_nop",         64'(dat),       64'h13);
    chk("range_err_set",     64'(range_err), 64'd1);
`else
    chk("range_mem_read",    64'(saw_mv),    64'd1);
    chk("range_alias_addr",  64'(mv_addr),   64'd0);
    chk("range_alias_dat",   64'(dat),       64'hA000_0000);
    chk("range_err_off",     64'(range_err), 64'd0);
`endif
    dat_rdy = 1'b1;
    tick; tick;
    chk("range_rsp_taken", 64'(dat_vld), 64'd0);
`ifdef L2_INS_RANGE_CHECK_EN
    chk("range_err_sticky", 64'(range_err), 64'd1);
`else
    chk("range_err_tied",   64'(range_err), 64'd0);
`endif
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    chk("range_err_cleared", 64'(range_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
